// File: rtl/vga_rect_fill_engine.sv
// rtl/vga_rect_fill_engine.sv - rectangle-fill command FIFO and frame-buffer write sequencer
// Expands queued (x, y, w, h, colour) fills into held/gapped image_word writes for the VGA CDC.
module vga_rect_fill_engine #(
  parameter int X_BITS      = 11,
  parameter int Y_BITS      = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_BITS-1:0] cmd_x,
  input  logic [Y_BITS-1:0] cmd_y,
  input  logic [X_BITS:0]   cmd_w,
  input  logic [Y_BITS:0]   cmd_h,
  input  logic [7:0]        cmd_color,
  output logic [31:0]       image_word,
  output logic              io_device_id,
  output logic              busy,
  output logic              done
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = X_BITS + Y_BITS + (X_BITS + 1) + (Y_BITS + 1) + 8;
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [X_BITS:0] X_SPAN    = {1'b1, {X_BITS{1'b0}}};
  localparam logic [Y_BITS:0] Y_SPAN    = {1'b1, {Y_BITS{1'b0}}};
  localparam logic [PW:0]     FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0]   HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]   GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_GAP, S_DONE} state_t;

  logic [CW-1:0]     r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PW:0]       r_count;
  state_t            r_state;
  logic [X_BITS-1:0] r_x, r_cx;
  logic [Y_BITS-1:0] r_y, r_cy;
  logic [X_BITS:0]   r_w, r_ew, r_col;
  logic [Y_BITS:0]   r_h, r_eh, r_row;
  logic [7:0]        r_color;
  logic [TW-1:0]     r_tmr;
  logic [31:0]       r_image_word;
  logic              r_io_device_id, r_done;

  logic              w_full, w_push, w_pop;
  logic [X_BITS-1:0] w_hx, w_nx;
  logic [Y_BITS-1:0] w_hy, w_ny;
  logic [X_BITS:0]   w_hw, w_room_x, w_ew;
  logic [Y_BITS:0]   w_hh, w_room_y, w_eh;
  logic [7:0]        w_hc;
  logic              w_last_col, w_last_row;

  function automatic logic [31:0] pix_word(input logic wen, input logic [7:0] color,
                                           input logic [X_BITS-1:0] px,
                                           input logic [Y_BITS-1:0] py);
    logic [14:0] addr;
    addr = 15'({py, px});
    return {8'h00, wen, color, addr};
  endfunction

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign w_full    = (r_count == FULL_CNT);
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign cmd_ready = !w_full;
  assign busy      = (r_count != '0) || (r_state != S_IDLE);
  assign {w_hx, w_hy, w_hw, w_hh, w_hc} = r_fifo[r_rd_ptr];

  // Clip at the frame edge instead of wrapping into the next row or column.
  assign w_room_x   = X_SPAN - {1'b0, r_x};
  assign w_room_y   = Y_SPAN - {1'b0, r_y};
  assign w_ew       = (r_w < w_room_x) ? r_w : w_room_x;
  assign w_eh       = (r_h < w_room_y) ? r_h : w_room_y;
  assign w_last_col = (r_col == r_ew - (X_BITS + 1)'(1));
  assign w_last_row = (r_row == r_eh - (Y_BITS + 1)'(1));
  assign w_nx       = w_last_col ? r_x : r_cx + X_BITS'(1);
  assign w_ny       = w_last_col ? r_cy + Y_BITS'(1) : r_cy;

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_image_word   <= '0;
      r_io_device_id <= 1'b1;
      r_done         <= 1'b0;
      r_tmr          <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_x            <= w_hx;
            r_y            <= w_hy;
            r_w            <= w_hw;
            r_h            <= w_hh;
            r_color        <= w_hc;
            r_io_device_id <= 1'b0;
            r_state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_ew == '0 || w_eh == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ew         <= w_ew;
            r_eh         <= w_eh;
            r_cx         <= r_x;
            r_cy         <= r_y;
            r_col        <= '0;
            r_row        <= '0;
            r_tmr        <= '0;
            r_image_word <= pix_word(1'b1, r_color, r_x, r_y);
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_tmr == HOLD_LAST) begin
            r_tmr            <= '0;
            r_image_word[23] <= 1'b0;
            r_state          <= S_GAP;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_GAP: begin
          if (r_tmr != GAP_LAST) begin
            r_tmr <= r_tmr + TW'(1);
          end else if (w_last_col && w_last_row) begin
            r_tmr   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmr        <= '0;
            r_cx         <= w_nx;
            r_cy         <= w_ny;
            r_col        <= w_last_col ? '0 : r_col + (X_BITS + 1)'(1);
            r_row        <= w_last_col ? r_row + (Y_BITS + 1)'(1) : r_row;
            r_image_word <= pix_word(1'b1, r_color, w_nx, w_ny);
            r_state      <= S_WRITE;
          end
        end
        S_DONE: begin
          r_io_device_id <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: begin
          r_io_device_id <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign image_word   = r_image_word;
  assign io_device_id = r_io_device_id;
  assign done         = r_done;
endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// tb/tb_vga_rect_fill_engine.sv - self-checking bench for vga_rect_fill_engine
module tb_vga_rect_fill_engine;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_x = '0;
  logic [3:0]  cmd_y = '0;
  logic [11:0] cmd_w = '0;
  logic [4:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [31:0] image_word;
  logic        io_device_id, busy, done;

  always #5 clk = ~clk;

  vga_rect_fill_engine dut (
    .clock(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .image_word(image_word), .io_device_id(io_device_id), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q_got[$];
  logic [31:0] q_exp[$];
  int done_at[$];
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  // Reference: every in-frame pixel of the rectangle, row-major; off-frame pixels are dropped.
  function automatic void model_cmd(input int x, input int y, input int w, input int h,
                                    input logic [7:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        if (x + k < 2048 && y + r < 16)
          q_exp.push_back({8'h00, 1'b1, c, 4'(y + r), 11'(x + k)});
  endfunction

  // Write monitor: one entry per wEn rising edge; each word must hold HOLD cycles then keep its data.
  logic        prev_wen = 1'b0, prev_done = 1'b0, stable = 1'b1;
  int          run_len = 0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wen  = 1'b0;
      prev_done = 1'b0;
      run_len   = 0;
    end else begin
      if (image_word[23]) begin
        if (!prev_wen) begin
          q_got.push_back(image_word);
          held    = image_word;
          run_len = 1;
          stable  = 1'b1;
          check("io_during_write", io_device_id, 0);
        end else begin
          run_len++;
          if (image_word !== held) stable = 1'b0;
        end
      end else if (prev_wen) begin
        check("hold_len", run_len, HOLD);
        check("hold_stable", stable, 1);
        check("gap_data", image_word[22:0], held[22:0]);
      end
      if (done) begin
        check("done_single", prev_done, 0);
        n_done++;
        done_at.push_back(q_got.size());
      end
      prev_wen  = image_word[23];
      prev_done = done;
    end
  end

  task automatic push(input int x, input int y, input int w, input int h, input logic [7:0] c);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) timeout("push_ready");
    cmd_x = 11'(x); cmd_y = 4'(y); cmd_w = 12'(w); cmd_h = 5'(h); cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x = 11'($urandom); cmd_y = 4'($urandom); cmd_w = 12'($urandom);
    cmd_h = 5'($urandom); cmd_color = 8'($urandom);
    model_cmd(x, y, w, h, c);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) timeout("wait_idle");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, q_got.size(), q_exp.size());
    for (int i = 0; i < q_got.size() && i < q_exp.size(); i++)
      check(name, q_got[i], q_exp[i]);
    q_got.delete();
    q_exp.delete();
  endtask

  typedef struct {
    int x; int y; int w; int h; logic [7:0] c;
    int n; logic [14:0] first; logic [14:0] last;
  } vec_t;

  initial begin
    vec_t vt[8];
    int   base, wb, db, t;
    vt[0] = '{5,    2,  1,    1,  8'hA5, 1,  15'h1005, 15'h1005};
    vt[1] = '{2046, 15, 3,    2,  8'h3C, 2,  15'h7FFE, 15'h7FFF};
    vt[2] = '{10,   3,  0,    5,  8'h01, 0,  15'h0000, 15'h0000};
    vt[3] = '{0,    0,  2,    2,  8'h11, 4,  15'h0000, 15'h0801};
    vt[4] = '{100,  14, 3,    0,  8'h02, 0,  15'h0000, 15'h0000};
    vt[5] = '{2040, 0,  2048, 1,  8'hC3, 8,  15'h07F8, 15'h07FF};
    vt[6] = '{7,    12, 5,    9,  8'h5E, 20, 15'h6007, 15'h780B};
    vt[7] = '{2047, 15, 1,    16, 8'hFF, 1,  15'h7FFF, 15'h7FFF};

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_image_word", image_word, 0);
    check("rst_io_device_id", io_device_id, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pixel cycle-by-cycle from push edge N
    push(5, 2, 1, 1, 8'hA5);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      check("px_word", image_word, (k == 1) ? 32'h0 : (k <= 5) ? 32'h00D2_9005 : 32'h0052_9005);
      check("px_done", done, (k == 10) ? 1 : 0);
      if (k == 1 || k >= 10) check("px_io", io_device_id, (k == 11) ? 1 : 0);
    end
    wait_idle(200);
    compare_queues("px_list");

    // Table of rectangles, one at a time
    for (int i = 0; i < 8; i++) begin
      db = n_done;
      push(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].c);
      wait_idle(2000);
      check("tbl_done_cnt", n_done - db, 1);
      check("tbl_n_writes", q_got.size(), vt[i].n);
      if (q_got.size() > 0 && vt[i].n > 0) begin
        check("tbl_first_addr", q_got[0][14:0], vt[i].first);
        check("tbl_last_addr", q_got[q_got.size() - 1][14:0], vt[i].last);
        check("tbl_color", q_got[0][22:15], vt[i].c);
      end
      compare_queues("tbl_list");
    end

    // Empty command immediately followed by a 2x2
    db = n_done;
    push(10, 4, 0, 3, 8'h44);
    push(20, 5, 2, 2, 8'h77);
    wait_idle(500);
    check("b2b_done_cnt", n_done - db, 2);
    if (done_at.size() >= db + 2) begin
      check("b2b_empty_no_write", done_at[db], 0);
      check("b2b_second_writes", done_at[db + 1], 4);
    end
    compare_queues("b2b_list");

    // Fill the FIFO while the engine works on the first command
    push(0, 1, 2, 1, 8'hB0);
    push(1, 1, 1, 1, 8'hB1);
    push(2, 1, 1, 1, 8'hB2);
    push(3, 1, 1, 1, 8'hB3);
    push(4, 1, 1, 1, 8'hB4);
    check("fifo_full_ready", cmd_ready, 0);
    check("fifo_full_busy", busy, 1);
    push(5, 1, 1, 1, 8'hB5);
    wait_idle(1000);
    compare_queues("fifo_order");

    // Reset during the second pixel's WRITE abandons everything
    push(100, 3, 3, 1, 8'h5A);
    push(0, 0, 1, 1, 8'h66);
    t = 0;
    while (!(q_got.size() == 2 && image_word[23]) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) timeout("second_pixel");
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_image_word", image_word, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_io", io_device_id, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wb = q_got.size();
    db = n_done;
    repeat (60) @(posedge clk);
    #1;
    check("mid_rst_writes", q_got.size(), 2);
    check("mid_rst_no_more", q_got.size() - wb, 0);
    check("mid_rst_no_done", n_done - db, 0);
    check("mid_rst_idle", busy, 0);
    q_got.delete();
    q_exp.delete();

    // Randomized stream of commands, back-to-back
    base = n_done;
    for (int i = 0; i < 12; i++) begin
      int rx;
      rx = ($urandom_range(0, 1) == 1) ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
      push(rx, $urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 3),
           8'($urandom));
    end
    wait_idle(5000);
    check("rand_done_cnt", n_done - base, 12);
    compare_queues("rand_list");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
